ccff_chain_loader: RTL and testbench
====================================

CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 1, giving the number of configuration bits in the downstream ccff chain; legal range 1..4096.
REQ-002 SHALL have port prog_clk, input, 1, the single clock for all logic.
REQ-003 SHALL have port pReset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, a one-cycle request to begin a chain load.
REQ-005 SHALL have port cfg_byte, input, 8, a configuration byte sent MSB first.
REQ-006 SHALL have port cfg_valid, input, 1, meaning cfg_byte is valid.
REQ-007 SHALL have port cfg_ready, output, 1, meaning the loader accepts cfg_byte this cycle.
REQ-008 SHALL have port ccff_head, output, 1, the serial data into the chain head.
REQ-009 SHALL have port config_enable, output, 1, the shift enable for the chain, high exactly on shift cycles.
REQ-010 SHALL have port ccff_tail, input, 1, the serial readback from the chain tail.
REQ-011 SHALL have port busy, output, 1, high while in LOAD.
REQ-012 SHALL have port done, output, 1, high while in DONE.
REQ-013 SHALL have port readback_parity, output, 1, the XOR of all tail bits sampled during the last load.

Function
REQ-014 SHALL implement the states IDLE, LOAD and DONE; all outputs SHALL be registered except cfg_ready.
REQ-015 SHALL, in IDLE or DONE, go to LOAD on the next edge when start=1, and clear the bit counter, byte counter, readback_parity and done.
REQ-016 SHALL ignore start while in LOAD.
REQ-017 SHALL drive cfg_ready = (state==LOAD) && (shift buffer empty) && (bits remaining > 0), so a handshake occurs on cfg_valid && cfg_ready.
REQ-018 SHALL, on an accepted byte, load the shift buffer with min(8, bits remaining) valid bits taken from cfg_byte[7] downward; the unused low bits of the final byte SHALL be discarded.
REQ-019 SHALL, on each cycle the buffer holds bits, register ccff_head = the next bit and config_enable = 1 for exactly that cycle, then decrement bits remaining.
REQ-020 SHALL, when the buffer is empty (input stall or handshake bubble), drive config_enable = 0 and hold ccff_head at its last value, so that no bit is lost or duplicated.
REQ-021 SHALL sustain at most 9 cycles per full byte: 1 handshake cycle plus 8 shift cycles.
REQ-022 SHALL, on the edge that ends each shift cycle, XOR ccff_tail into readback_parity; this samples the chain's previous contents in order.
REQ-023 SHALL, after the cycle that shifts bit CHAIN_LEN, go to DONE on the next edge with config_enable=0 and done=1.
REQ-024 SHALL hold done and readback_parity stable in DONE until the next start.
REQ-025 SHALL size the bit counter to clog2(CHAIN_LEN+1) bits, with no wrap; the counter SHALL saturate at 0.
REQ-026 SHALL require exactly ceil(CHAIN_LEN/8) handshakes per load; cfg_valid outside LOAD SHALL be ignored.

Reset
REQ-027 SHALL, on pReset=1 at an edge, force IDLE and clear cfg_ready, ccff_head, config_enable, busy, done, readback_parity, the counters and the buffer.
REQ-028 SHALL give pReset priority over start and handshakes; a reset during LOAD abandons the load and does not restore the partially shifted chain.

Verification
REQ-029 SHALL verify reset: hold pReset for 2 cycles with random inputs -> all outputs 0 and state IDLE.
REQ-030 SHALL verify CHAIN_LEN=1: start, then byte 0x80 -> a single config_enable pulse with ccff_head=1, done=1 on the next edge, and low bits discarded.
REQ-031 SHALL verify CHAIN_LEN=20 with bytes 0xA5, 0x3C, 0xF0 -> 20 enable pulses, head sequence 10100101 00111100 1111, exactly 3 handshakes, and a chain model holding that pattern.
REQ-032 SHALL verify an input stall: hold cfg_valid low 5 cycles after the first byte drains -> config_enable low and ccff_head held during the stall, with the final chain contents identical to REQ-031.
REQ-033 SHALL verify reset mid-load: assert pReset after 10 shifts -> IDLE next cycle with outputs 0; a subsequent start performs a full 20-bit reload correctly.
REQ-034 SHALL verify readback: preload the chain model with 0x00007 (3 ones), then load 20 bits -> readback_parity=1; preload 0xFFFFF -> readback_parity=0; start during LOAD -> no effect.

Source files
------------

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
//
// Serialises a stream of configuration bytes into a downstream ccff
// (configuration flip-flop) shift chain of CHAIN_LEN bits. Bytes arrive
// over a valid/ready handshake and are shifted MSB first. Each byte takes
// one handshake cycle and then up to eight shift cycles. While it shifts,
// the loader XORs every bit that falls out of the chain tail into a
// readback parity.
//
// Ports
//   prog_clk         in   single clock for all logic
//   pReset           in   synchronous active-high reset
//   start            in   one-cycle request to begin a chain load
//   cfg_byte[7:0]    in   configuration byte, sent MSB first
//   cfg_valid        in   cfg_byte is valid
//   cfg_ready        out  loader accepts cfg_byte this cycle (combinational)
//   ccff_head        out  serial data into the chain head (registered)
//   config_enable    out  chain shift enable, high on shift cycles only
//   ccff_tail        in   serial readback from the chain tail
//   busy             out  high while a load is in progress
//   done             out  high once a load has completed
//   readback_parity  out  XOR of all tail bits sampled during the last load

module ccff_chain_loader #(
    parameter int CHAIN_LEN = 1
) (
    input  logic       prog_clk,
    input  logic       pReset,
    input  logic       start,
    input  logic [7:0] cfg_byte,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    output logic       ccff_head,
    output logic       config_enable,
    input  logic       ccff_tail,
    output logic       busy,
    output logic       done,
    output logic       readback_parity
);

    localparam int CW = $clog2(CHAIN_LEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] bits_left;
    logic [CW-1:0] bits_left_next;
    logic [7:0]    shift_buf;
    logic [7:0]    shift_buf_next;
    logic [3:0]    buf_cnt;
    logic [3:0]    buf_cnt_next;
    logic          head_next;
    logic          enable_next;
    logic          parity_next;
    logic          busy_next;
    logic          done_next;
    logic [12:0]   bits_left_wide;
    logic          handshake;

    // Widen the counter to a fixed width so the min(8, bits_left) test
    // is well formed for every CHAIN_LEN, including CHAIN_LEN = 1.
    assign bits_left_wide = 13'(bits_left);

    // A byte is requested only when the buffer has fully drained and bits
    // remain. bits_left counts bits that have not been shifted yet. An
    // empty buffer means every accepted bit has already gone out, so
    // bits_left equals the bits still to be fetched. The ready is masked
    // during reset so that upstream never sees a handshake the loader
    // then discards.
    assign cfg_ready = (state == LOAD) && (buf_cnt == 4'd0) &&
                       (bits_left != '0) && !pReset;
    assign handshake = cfg_valid && cfg_ready;

    // Next-state and next-output logic. Every output apart from cfg_ready
    // is registered, so this block computes the values the outputs take
    // after the coming edge.
    always_comb begin
        state_next     = state;
        bits_left_next = bits_left;
        shift_buf_next = shift_buf;
        buf_cnt_next   = buf_cnt;
        head_next      = ccff_head;
        enable_next    = 1'b0;
        parity_next    = readback_parity;

        // A high config_enable marks a cycle in which the chain shifts on
        // the coming edge. The bit leaving the tail on that edge is an old
        // chain bit, so it is folded into the parity.
        if (config_enable) begin
            parity_next = readback_parity ^ ccff_tail;
        end

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next     = LOAD;
                    bits_left_next = CW'(CHAIN_LEN);
                    shift_buf_next = 8'd0;
                    buf_cnt_next   = 4'd0;
                    parity_next    = 1'b0;
                end
            end

            LOAD: begin
                if (buf_cnt != 4'd0) begin
                    head_next      = shift_buf[7];
                    enable_next    = 1'b1;
                    shift_buf_next = {shift_buf[6:0], 1'b0};
                    buf_cnt_next   = buf_cnt - 4'd1;
                    if (bits_left != '0) begin
                        bits_left_next = bits_left - CW'(1);
                    end
                end else if (bits_left == '0) begin
                    // The final bit is on config_enable this cycle, so its
                    // shift completes on this edge.
                    state_next = DONE;
                end else if (handshake) begin
                    // Only the top min(8, bits_left) bits are ever shifted.
                    // Low bits past the end of the chain stay unused in the
                    // buffer.
                    shift_buf_next = cfg_byte;
                    buf_cnt_next   = (bits_left_wide >= 13'd8) ? 4'd8
                                                               : bits_left_wide[3:0];
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next == LOAD);
        done_next = (state_next == DONE);
    end

    // State and output registers with synchronous reset. Reset abandons a
    // load in progress. The chain contents are not touched.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state           <= IDLE;
            bits_left       <= '0;
            shift_buf       <= 8'd0;
            buf_cnt         <= 4'd0;
            ccff_head       <= 1'b0;
            config_enable   <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            readback_parity <= 1'b0;
        end else begin
            state           <= state_next;
            bits_left       <= bits_left_next;
            shift_buf       <= shift_buf_next;
            buf_cnt         <= buf_cnt_next;
            ccff_head       <= head_next;
            config_enable   <= enable_next;
            busy            <= busy_next;
            done            <= done_next;
            readback_parity <= parity_next;
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader
//
// This bench instantiates the loader twice: once with a 1-bit chain and
// once with a 20-bit chain. A behavioural model of each downstream ccff
// chain drives ccff_tail. Expected head streams, final chain contents,
// handshake counts and readback parity come from the bytes and preload
// values alone.

module tb_ccff_chain_loader;

    logic prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    logic       pReset;

    logic       start20, valid20, ready20, head20, en20, tail20, busy20, done20, par20;
    logic [7:0] byte20;
    logic       start1, valid1, ready1, head1, en1, tail1, busy1, done1, par1;
    logic [7:0] byte1;

    int n_checks = 0;
    int n_fail   = 0;

    ccff_chain_loader #(.CHAIN_LEN(20)) dut20 (
        .prog_clk        (prog_clk),
        .pReset          (pReset),
        .start           (start20),
        .cfg_byte        (byte20),
        .cfg_valid       (valid20),
        .cfg_ready       (ready20),
        .ccff_head       (head20),
        .config_enable   (en20),
        .ccff_tail       (tail20),
        .busy            (busy20),
        .done            (done20),
        .readback_parity (par20)
    );

    ccff_chain_loader #(.CHAIN_LEN(1)) dut1 (
        .prog_clk        (prog_clk),
        .pReset          (pReset),
        .start           (start1),
        .cfg_byte        (byte1),
        .cfg_valid       (valid1),
        .cfg_ready       (ready1),
        .ccff_head       (head1),
        .config_enable   (en1),
        .ccff_tail       (tail1),
        .busy            (busy1),
        .done            (done1),
        .readback_parity (par1)
    );

    // Downstream chain models. Each one shifts head in whenever its enable
    // is high and can be preloaded from the stimulus process.
    logic [19:0] chain20;
    logic [19:0] chain20_val;
    logic        chain20_load;
    logic        chain1;
    logic        chain1_val;
    logic        chain1_load;

    assign tail20 = chain20[19];
    assign tail1  = chain1;

    always @(posedge prog_clk) begin
        if (chain20_load)  chain20 <= chain20_val;
        else if (en20)     chain20 <= {chain20[18:0], head20};
        if (chain1_load)   chain1 <= chain1_val;
        else if (en1)      chain1 <= head1;
    end

    // Monitors record every handshake and every bit the chain sees.
    int hs20    = 0;
    int hs1     = 0;
    int pulses1 = 0;
    bit pulses20[$];

    always @(posedge prog_clk) begin
        if (!pReset && valid20 && ready20) hs20++;
        if (!pReset && valid1 && ready1)   hs1++;
        if (en20) pulses20.push_back(head20);
        if (en1)  pulses1++;
    end

    // Watchdog against a hung run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge prog_clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", name, observed, expected);
        end
    endtask

    // One complete 1-bit load: preload the chain, start, send one byte.
    task automatic d1Run(input logic [7:0] b, input logic pre, input string tag);
        int hb;
        int pb;
        chain1_val = pre; chain1_load = 1'b1; tick(1); chain1_load = 1'b0;
        hb = hs1; pb = pulses1;
        start1 = 1'b1; tick(1); start1 = 1'b0;
        checkOutput({tag, "_ready"}, 32'(ready1), 32'd1);
        valid1 = 1'b1; byte1 = b; tick(1); valid1 = 1'b0; byte1 = 8'($urandom);
        checkOutput({tag, "_bubble_en"}, 32'(en1), 32'd0);
        tick(1);
        checkOutput({tag, "_en"}, 32'(en1), 32'd1);
        checkOutput({tag, "_head"}, 32'(head1), 32'(b[7]));
        tick(1);
        checkOutput({tag, "_done_busy_en"}, 32'({done1, busy1, en1}), 32'b100);
        checkOutput({tag, "_parity"}, 32'(par1), 32'(pre));
        checkOutput({tag, "_chain"}, 32'(chain1), 32'(b[7]));
        // A valid outside LOAD must be ignored, and DONE must hold.
        valid1 = 1'b1; tick(3); valid1 = 1'b0;
        checkOutput({tag, "_pulses"}, 32'(pulses1 - pb), 32'd1);
        checkOutput({tag, "_handshakes"}, 32'(hs1 - hb), 32'd1);
        checkOutput({tag, "_hold"}, 32'({done1, par1}), 32'({1'b1, pre}));
    endtask

    // One complete 20-bit load of three bytes, with an optional input
    // stall after the first byte and an optional start pulse mid-load.
    task automatic applyStimulus(input logic [7:0] b0, input logic [7:0] b1,
                                 input logic [7:0] b2, input logic [19:0] preload,
                                 input int stall, input bit start_mid, input string tag);
        logic [7:0]  bytes [3];
        logic [23:0] stream;
        logic [19:0] exp_chain;
        logic [19:0] obs_heads;
        int          hs_base;
        int          p_base;
        int          exp_par;
        bit          got;
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
        stream    = {b0, b1, b2};
        exp_chain = stream[23:4];
        exp_par   = $countones(preload) % 2;

        chain20_val = preload; chain20_load = 1'b1; tick(1); chain20_load = 1'b0;
        hs_base = hs20; p_base = pulses20.size();
        start20 = 1'b1; tick(1); start20 = 1'b0;
        checkOutput({tag, "_busy"}, 32'(busy20), 32'd1);

        for (int i = 0; i < 3; i++) begin
            byte20 = bytes[i]; valid20 = 1'b1;
            got = 1'b0;
            for (int w = 0; w < 40 && !got; w++) begin
                tick(1);
                if (hs20 > hs_base + i) got = 1'b1;
            end
            valid20 = 1'b0; byte20 = 8'($urandom);
            if (!got) checkOutput({tag, "_hs_timeout"}, 32'd0, 32'd1);
            if (i == 0 && stall > 0) begin
                got = 1'b0;
                for (int w = 0; w < 40 && !got; w++) begin
                    if (ready20) got = 1'b1;
                    else tick(1);
                end
                if (!got) checkOutput({tag, "_drain_timeout"}, 32'd0, 32'd1);
                for (int k = 0; k < stall; k++) begin
                    tick(1);
                    checkOutput({tag, "_stall_en"}, 32'(en20), 32'd0);
                    checkOutput({tag, "_stall_head"}, 32'(head20), 32'(b0[0]));
                end
            end
            if (i == 1 && start_mid) begin
                start20 = 1'b1; tick(1); start20 = 1'b0;
            end
        end

        got = 1'b0;
        for (int w = 0; w < 60 && !got; w++) begin
            if (done20) got = 1'b1;
            else tick(1);
        end
        if (!got) checkOutput({tag, "_done_timeout"}, 32'd0, 32'd1);

        obs_heads = '0;
        for (int j = 0; j < 20; j++) begin
            if (p_base + j < pulses20.size()) obs_heads[19 - j] = pulses20[p_base + j];
        end
        checkOutput({tag, "_pulses"}, 32'(pulses20.size() - p_base), 32'd20);
        checkOutput({tag, "_heads"}, 32'(obs_heads), 32'(exp_chain));
        checkOutput({tag, "_handshakes"}, 32'(hs20 - hs_base), 32'd3);
        checkOutput({tag, "_chain"}, 32'(chain20), 32'(exp_chain));
        checkOutput({tag, "_parity"}, 32'(par20), 32'(exp_par));
        checkOutput({tag, "_flags"}, 32'({busy20, en20}), 32'd0);
        tick(3);
        checkOutput({tag, "_hold"}, 32'({done20, par20, en20}), 32'({1'b1, exp_par[0], 1'b0}));
    endtask

    initial begin
        logic [19:0] pre;
        int          hsb;
        int          pb;
        bit          got;

        pReset = 1'b1;
        start20 = 1'b0; valid20 = 1'b0; byte20 = 8'd0;
        start1  = 1'b0; valid1  = 1'b0; byte1  = 8'd0;
        chain20_val = 20'd0; chain20_load = 1'b1;
        chain1_val  = 1'b0;  chain1_load  = 1'b1;

        // Reset held for two edges with random inputs.
        for (int k = 0; k < 2; k++) begin
            start20 = 1'($urandom); valid20 = 1'($urandom); byte20 = 8'($urandom);
            start1  = 1'($urandom); valid1  = 1'($urandom); byte1  = 8'($urandom);
            tick(1);
        end
        chain20_load = 1'b0; chain1_load = 1'b0;
        checkOutput("reset20", 32'({busy20, done20, en20, head20, par20, ready20}), 32'd0);
        checkOutput("reset1", 32'({busy1, done1, en1, head1, par1, ready1}), 32'd0);
        pReset = 1'b0;
        start20 = 1'b0; valid20 = 1'b0; start1 = 1'b0; valid1 = 1'b0;
        tick(1);
        checkOutput("idle20", 32'({busy20, done20, ready20}), 32'd0);

        $display("[TB] 1-bit chain loads");
        d1Run(8'h80, 1'b0, "len1_80");
        d1Run(8'h7F, 1'b1, "len1_7F");

        $display("[TB] 20-bit chain loads");
        applyStimulus(8'hA5, 8'h3C, 8'hF0, 20'h00000, 0, 1'b0, "len20");
        applyStimulus(8'hA5, 8'h3C, 8'hF0, 20'h12345, 5, 1'b0, "stall");

        $display("[TB] reset in the middle of a load");
        chain20_val = 20'($urandom); chain20_load = 1'b1; tick(1); chain20_load = 1'b0;
        hsb = hs20; pb = pulses20.size();
        start20 = 1'b1; tick(1); start20 = 1'b0;
        byte20 = 8'hA5; valid20 = 1'b1;
        got = 1'b0;
        for (int w = 0; w < 60 && !got; w++) begin
            tick(1);
            if (hs20 > hsb && byte20 == 8'hA5) byte20 = 8'h3C;
            if (pulses20.size() - pb >= 10) got = 1'b1;
        end
        if (!got) checkOutput("midreset_timeout", 32'd0, 32'd1);
        pReset = 1'b1; valid20 = 1'b0;
        tick(1);
        checkOutput("midreset_out", 32'({busy20, done20, en20, head20, par20, ready20}), 32'd0);
        pReset = 1'b0;
        tick(1);
        checkOutput("midreset_idle", 32'({busy20, done20, en20, ready20}), 32'd0);
        applyStimulus(8'hA5, 8'h3C, 8'hF0, 20'($urandom), 0, 1'b0, "reload");

        $display("[TB] readback parity and start during load");
        applyStimulus(8'hA5, 8'h3C, 8'hF0, 20'h00007, 0, 1'b1, "rb_odd");
        applyStimulus(8'h5A, 8'hC3, 8'h0F, 20'hFFFFF, 2, 1'b1, "rb_even");

        $display("[TB] random loads");
        for (int r = 0; r < 4; r++) begin
            pre = 20'($urandom);
            applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), pre,
                          int'($urandom_range(0, 6)), 1'($urandom), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
